// File: rtl/uart_pkg.sv
// Shared UART receive definitions: framing constants and the receiver FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and its consumer; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] wdata,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic                      do_push;
    logic                      do_pop;

    // The extra pointer bit separates "full" from "empty" when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM, and a small receive FIFO
// with one-cycle frame-error and overrun pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_IDX = 3'(UART_DATA_BITS - 1);

    rx_state_e                 state;
    rx_state_e                 next_state;
    logic                      sync_q1;
    logic                      sync_q2;
    logic                      rx_prev;
    logic [15:0]               baud_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      half_tick;
    logic                      bit_tick;
    logic                      fall;
    logic                      baud_clr;
    logic                      sample_bit;
    logic                      push;
    logic                      frame_err_set;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;

    assign half_tick = (baud_cnt == HALF_BIT);
    assign bit_tick  = (baud_cnt == BIT_LAST);
    assign fall      = rx_prev && !sync_q2;

    // Synchronizer and edge history reset high so a released reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_q1 <= uart_rx;
            sync_q2 <= sync_q1;
            rx_prev <= sync_q2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        next_state = state;
        case (state)
            RX_IDLE:      if (fall) next_state = RX_START;
            RX_START:     if (half_tick) next_state = sync_q2 ? RX_IDLE : RX_DATA;
            RX_DATA:      if (bit_tick && bit_cnt == LAST_IDX) next_state = RX_STOP;
            RX_STOP:      if (bit_tick) next_state = sync_q2 ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (sync_q2) next_state = RX_IDLE;
            default:      next_state = RX_IDLE;
        endcase
    end

    always_comb begin
        baud_clr      = 1'b0;
        sample_bit    = 1'b0;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            RX_IDLE:      baud_clr = 1'b1;
            RX_START:     baud_clr = half_tick;
            RX_DATA: begin
                baud_clr   = bit_tick;
                sample_bit = bit_tick;
            end
            RX_STOP: begin
                baud_clr      = bit_tick;
                push          = bit_tick && sync_q2;
                frame_err_set = bit_tick && !sync_q2;
            end
            RX_WAIT_IDLE: baud_clr = 1'b1;
            default:      baud_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            baud_cnt <= baud_clr ? 16'd0 : baud_cnt + 16'd1;
            if (state == RX_IDLE) begin
                bit_cnt <= '0;
            end else if (sample_bit) begin
                bit_cnt        <= bit_cnt + 3'd1;
                shift[bit_cnt] <= sync_q2;
            end
        end
    end

    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;

    // Both pulses come from mutually exclusive stop-bit outcomes, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err_set;
            overrun   <= push && fifo_full && !pop;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shift),
        .pop   (pop),
        .rdata (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_core;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int total;
    int bad;

    logic [7:0] got[$];
    int         valid_cycles;
    int         fe_cnt;
    int         ov_cnt;
    int         both_cnt;

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe outputs on the falling edge, away from the edge where inputs change.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (rx_valid) valid_cycles++;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got.delete();
        valid_cycles = 0;
        fe_cnt       = 0;
        ov_cnt       = 0;
        both_cnt     = 0;
    endtask

    // Stop bit sample falls on the 12th clock of the stop bit, so a one-cycle
    // rx_ready there lines the pop up with the push.
    task automatic send_frame(input logic [7:0] data, input int stop_low, input bit pop_at_stop);
        uart_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (CPB) tick();
        end
        if (stop_low > 0) begin
            uart_rx = 1'b0;
            repeat (stop_low) tick();
        end
        uart_rx = 1'b1;
        for (int i = 1; i <= CPB; i++) begin
            tick();
            if (pop_at_stop) rx_ready = (i == 11);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        clear_mon();
        repeat (3) tick();
        total++; if (rx_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00)  begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_basic();
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'hA5, 0, 1'b0);
        total++; if (got.size() != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", got.size()); end
        else begin
            total++; if (got[0] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", got[0]); end
        end
        total++; if (valid_cycles != 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cycles); end
        total++; if (fe_cnt != 0) begin bad++; $display("FAIL basic_frame_err got=%0d exp=0", fe_cnt); end
        total++; if (ov_cnt != 0) begin bad++; $display("FAIL basic_overrun got=%0d exp=0", ov_cnt); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'h3C, 32, 1'b0);
        total++; if (fe_cnt != 1) begin bad++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt); end
        total++; if (got.size() != 0) begin bad++; $display("FAIL ferr_no_byte got=%0d exp=0", got.size()); end
        send_frame(8'h55, 0, 1'b0);
        total++; if (got.size() != 1) begin bad++; $display("FAIL ferr_next_count got=%0d exp=1", got.size()); end
        else begin
            total++; if (got[0] !== 8'h55) begin bad++; $display("FAIL ferr_next_data got=%h exp=55", got[0]); end
        end
        total++; if (fe_cnt != 1) begin bad++; $display("FAIL ferr_after got=%0d exp=1", fe_cnt); end
        total++; if (ov_cnt != 0) begin bad++; $display("FAIL ferr_overrun got=%0d exp=0", ov_cnt); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_ready = 1'b1;
        uart_rx  = 1'b0;
        repeat (4) tick();
        uart_rx = 1'b1;
        repeat (40) tick();
        total++; if (got.size() != 0 || fe_cnt != 0 || ov_cnt != 0) begin
            bad++; $display("FAIL glitch_quiet bytes=%0d ferr=%0d ovr=%0d exp=0/0/0", got.size(), fe_cnt, ov_cnt);
        end
        send_frame(8'hC3, 0, 1'b0);
        total++; if (got.size() != 1 || got[0] !== 8'hC3) begin
            bad++; $display("FAIL glitch_recover bytes=%0d exp=1 (c3)", got.size());
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_bytes[4];
        exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        clear_mon();
        rx_ready = 1'b0;
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 0, 1'b0);
        total++; if (ov_cnt != 0) begin bad++; $display("FAIL ovr_early got=%0d exp=0", ov_cnt); end
        send_frame(8'h05, 0, 1'b0);
        total++; if (ov_cnt != 1) begin bad++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt); end
        total++; if (fe_cnt != 0) begin bad++; $display("FAIL ovr_frame_err got=%0d exp=0", fe_cnt); end
        total++; if (rx_data !== 8'h01) begin bad++; $display("FAIL ovr_head got=%h exp=01", rx_data); end
        rx_ready = 1'b1;
        repeat (8) tick();
        total++; if (got.size() != 4) begin bad++; $display("FAIL ovr_drain_count got=%0d exp=4", got.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got[i] !== exp_bytes[i]) begin bad++; $display("FAIL ovr_drain[%0d] got=%h exp=%h", i, got[i], exp_bytes[i]); end
            end
        end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_empty got=%b exp=0", rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        rx_ready = 1'b0;
        send_frame(8'h42, 0, 1'b0);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rst_prefill got=%b exp=1", rx_valid); end
        uart_rx = 1'b0;
        repeat (CPB) tick();
        uart_rx = 1'b1;
        repeat (3 * CPB + 8) tick();
        rst = 1'b1;
        #1;
        total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL rst_outputs valid=%b data=%h ferr=%b ovr=%b exp=0/00/0/0", rx_valid, rx_data, frame_err, overrun);
        end
        repeat (3) tick();
        rst = 1'b0;
        repeat (5 * CPB) tick();
        total++; if (rx_valid !== 1'b0 || fe_cnt != 0) begin
            bad++; $display("FAIL rst_tail valid=%b ferr=%0d exp=0/0", rx_valid, fe_cnt);
        end
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'h81, 0, 1'b0);
        total++; if (got.size() != 1 || got[0] !== 8'h81) begin
            bad++; $display("FAIL rst_next bytes=%0d exp=1 (81)", got.size());
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_bytes[4];
        exp_bytes = '{8'h22, 8'h33, 8'h44, 8'h99};
        clear_mon();
        rx_ready = 1'b0;
        send_frame(8'h11, 0, 1'b0);
        send_frame(8'h22, 0, 1'b0);
        send_frame(8'h33, 0, 1'b0);
        send_frame(8'h44, 0, 1'b0);
        send_frame(8'h99, 0, 1'b1);
        total++; if (ov_cnt != 0) begin bad++; $display("FAIL full_pp_overrun got=%0d exp=0", ov_cnt); end
        total++; if (got.size() != 1 || got[0] !== 8'h11) begin
            bad++; $display("FAIL full_pp_pop bytes=%0d exp=1 (11)", got.size());
        end
        clear_mon();
        rx_ready = 1'b1;
        repeat (8) tick();
        total++; if (got.size() != 4) begin bad++; $display("FAIL full_pp_count got=%0d exp=4", got.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got[i] !== exp_bytes[i]) begin bad++; $display("FAIL full_pp[%0d] got=%h exp=%h", i, got[i], exp_bytes[i]); end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_reset_mid_frame();
        test_full_push_pop();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL pulses_together got=%0d exp=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
